// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer sitting between a UART
// receiver and its consumer.
//
// Characters arrive on a one-cycle Rx_Valid strobe. Any character flagged
// with a receiver error (break/parity/frame) is discarded without touching
// state. Good characters go into a circular buffer. The consumer pulses
// Read_Done to move the oldest entry onto Data_Out, where it is valid from
// the following cycle. When the buffer is completely full and no pop
// happens in the same cycle, an incoming character is dropped and the
// sticky FIFO_Overflow flag is set. The next successful pop clears it.
// FIFO_Full (and RTS, its inverse) assert at half occupancy. This gives the
// sender a half-buffer of headroom to react to RTS before anything is lost.
//
// Ports
//   Clk            clock, rising edge
//   Rst            asynchronous reset, active low
//   Rx_Data        character from the receiver
//   Rx_Valid       one-cycle strobe qualifying Rx_Data / Rx_Error
//   Rx_Error       [0] break, [1] parity, [2] frame
//   Read_Done      consumer strobe, pops one entry per cycle held
//   Data_Out       most recently popped character
//   FIFO_Empty     Count == 0
//   FIFO_Full      Count >= FIFO_DEPTH/2
//   FIFO_Overflow  sticky: a character was dropped since the last pop
//   RTS            !FIFO_Full
//   Count          occupancy, 0..FIFO_DEPTH
//
// FIFO_DEPTH must be a power of two and at least 4. Pointer wrap relies on
// natural binary overflow of the pointer width.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [DATA_BITS-1:0]          Rx_Data,
  input  logic                          Rx_Valid,
  input  logic [2:0]                    Rx_Error,
  input  logic                          Read_Done,
  output logic [DATA_BITS-1:0]          Data_Out,
  output logic                          FIFO_Empty,
  output logic                          FIFO_Full,
  output logic                          FIFO_Overflow,
  output logic                          RTS,
  output logic [$clog2(FIFO_DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(FIFO_DEPTH / 2);

  // Storage is deliberately left without a reset. Count gates every read,
  // so stale contents can never reach Data_Out.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 ovf_q, ovf_d;

  logic push_req, pop, push, drop, at_depth;

  always_comb begin
    push_req = Rx_Valid && (Rx_Error == 3'b000);
    at_depth = (count_q == DEPTH_C);
    pop      = Read_Done && (count_q != '0);
    // A full buffer still accepts a character when a pop frees the slot
    // on the same edge. The write lands on the slot being read out. The
    // read sees the old contents because the write is non-blocking.
    push     = push_req && (!at_depth || pop);
    drop     = push_req && at_depth && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    ovf_d      = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Drop takes priority over the clear. In practice the two cannot
    // coincide, because a pop always makes room for the push.
    if (drop)     ovf_d = 1'b1;
    else if (pop) ovf_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
    end
  end

  // Writes are blocked while reset is held. This keeps the "no push during
  // reset" behaviour explicit even for the unreset storage.
  always_ff @(posedge Clk) begin
    if (push && Rst) mem_q[wr_ptr_q] <= Rx_Data;
  end

  assign Data_Out      = data_out_q;
  assign Count         = count_q;
  assign FIFO_Overflow = ovf_q;
  assign FIFO_Empty    = (count_q == '0);
  assign FIFO_Full     = (count_q >= HALF_C);
  assign RTS           = !FIFO_Full;

endmodule
